// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line levels and width helper
package uart_pkg;

  // Frame sequencing states shared by the transmit and receive paths
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with terminal-count strobe
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = width_of(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign bit_end = (r_cnt == LAST);

  // Count 0..CLKS_PER_BIT-1 and wrap; held at 0 while cleared
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      r_cnt <= '0;
    end else if (bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, optional parity bit via UART_TX_PARITY_EN
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 DATA_VALID,
  output logic                 READY,
  output logic                 TX,
  output logic                 BUSY
);

  localparam int BW = width_of(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_next;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 w_tx_next;
  logic                 w_bit_end;
  logic                 w_clear;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
  logic                 w_par_next;
  localparam logic      ODD_SENSE = (PARITY_ODD != 0);
`else
  localparam int        unused_parity_odd = PARITY_ODD;
`endif

  // Baud counter sits at 0 in IDLE so the start bit gets a full period
  assign w_clear = (r_state == S_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (w_clear),
    .bit_end(w_bit_end)
  );

  // Next state, shift/bit counters, and the line level the next state drives
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit_cnt;
`ifdef UART_TX_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (DATA_VALID) begin
          w_state_next = S_START;
          w_shift_next = DATA;
          w_bit_next   = '0;
`ifdef UART_TX_PARITY_EN
          w_par_next   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          // Parity accumulates from the latched bits as they leave the shifter
          w_shift_next = r_shift >> 1;
`ifdef UART_TX_PARITY_EN
          w_par_next   = r_par ^ r_shift[0];
`endif
          if (r_bit_cnt == LAST_DATA) begin
            w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        // Bit counter is reused to count stop periods
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_state_next = S_IDLE;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    case (w_state_next)
      S_START:  w_tx_next = LINE_START;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = w_par_next ^ ODD_SENSE;
`endif
      default:  w_tx_next = LINE_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any frame with the line high
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= LINE_IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_next;
      r_tx      <= w_tx_next;
      r_ready   <= (w_state_next == S_IDLE);
      r_busy    <= (w_state_next != S_IDLE);
`ifdef UART_TX_PARITY_EN
      r_par     <= w_par_next;
`endif
    end
  end

  assign TX    = r_tx;
  assign READY = r_ready;
  assign BUSY  = r_busy;

endmodule
